// File: rtl/line_buffer_bank.sv
// Ring-filled bank of line buffers with a registered one-cycle column read.
// Build option LINEBUF_ROTATE_EN: output lane 0 always carries the oldest line.
module line_buffer_bank #(
    parameter int NUM_LANES = 13,
    parameter int DEPTH     = 19,
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 4,
    parameter int ADDR_W    = 5,
    localparam int CNT_W    = $clog2(NUM_LANES + 1),
    localparam int LANE_W   = $clog2(NUM_LANES),
    localparam int WORD_W   = TAG_W + DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    input  logic                          line_release,
    input  logic                          rd_en,
    input  logic [ADDR_W-1:0]             rd_addr,
    input  logic [NUM_LANES-1:0]          rd_lane_en,
    input  logic [NUM_LANES*TAG_W-1:0]    rd_tag,
    output logic                          rd_valid,
    output logic [NUM_LANES*DATA_W-1:0]   rd_data,
    output logic [NUM_LANES*WORD_W-1:0]   rd_word,
    output logic [CNT_W-1:0]              lines_valid,
    output logic [LANE_W-1:0]             head_lane,
    output logic [LANE_W-1:0]             wr_lane,
    output logic                          rd_err
);

    logic [DATA_W-1:0] mem [NUM_LANES][DEPTH];

    logic [ADDR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [LANE_W-1:0]           wr_lane_q, wr_lane_d;
    logic [LANE_W-1:0]           head_lane_q, head_lane_d;
    logic [CNT_W-1:0]            lines_valid_q, lines_valid_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        rd_err_q, rd_err_d;
    logic [NUM_LANES*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_LANES*WORD_W-1:0] rd_word_q, rd_word_d;

    logic wr_fire;
    logic line_done;
    logic rel;
    logic addr_bad;

    logic [LANE_W-1:0] phys [NUM_LANES];
    logic [DATA_W-1:0] lane_rd [NUM_LANES];

    function automatic logic [LANE_W-1:0] lane_inc(input logic [LANE_W-1:0] l);
        return (l == LANE_W'(NUM_LANES - 1)) ? '0 : l + 1'b1;
    endfunction

    assign wr_ready  = (lines_valid_q < CNT_W'(NUM_LANES));
    assign wr_fire   = wr_valid && wr_ready;
    assign line_done = wr_fire && (wr_ptr_q == ADDR_W'(DEPTH - 1));
    assign rel       = line_release && (lines_valid_q != '0);
    assign addr_bad  = (rd_addr >= ADDR_W'(DEPTH));

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        wr_lane_d     = wr_lane_q;
        head_lane_d   = head_lane_q;
        lines_valid_d = lines_valid_q + CNT_W'(line_done) - CNT_W'(rel);
        if (wr_fire) begin
            wr_ptr_d = line_done ? '0 : wr_ptr_q + 1'b1;
        end
        if (line_done) begin
            wr_lane_d = lane_inc(wr_lane_q);
        end
        if (rel) begin
            head_lane_d = lane_inc(head_lane_q);
        end
    end

`ifdef LINEBUF_ROTATE_EN
    // Logical lane k maps to the k-th oldest physical line.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            logic [LANE_W:0] sum;
            sum = {1'b0, head_lane_q} + (LANE_W + 1)'(k);
            if (sum >= (LANE_W + 1)'(NUM_LANES)) begin
                sum = sum - (LANE_W + 1)'(NUM_LANES);
            end
            phys[k] = sum[LANE_W-1:0];
        end
    end
`else
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            phys[k] = LANE_W'(k);
        end
    end
`endif

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_rd[k] = '0;
            if (!addr_bad && rd_lane_en[k]) begin
                lane_rd[k] = mem[phys[k]][rd_addr];
            end
        end
    end

    always_comb begin
        rd_valid_d = rd_en;
        rd_err_d   = rd_err_q || (rd_en && addr_bad);
        rd_data_d  = rd_data_q;
        rd_word_d  = rd_word_q;
        if (rd_en) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                rd_data_d[k*DATA_W +: DATA_W] = lane_rd[k];
                rd_word_d[k*WORD_W +: WORD_W] = {rd_tag[k*TAG_W +: TAG_W], lane_rd[k]};
            end
        end
    end

    // Memory is not reset; the nonblocking write gives read-before-write.
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire) begin
            mem[wr_lane_q][wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            wr_lane_q     <= '0;
            head_lane_q   <= '0;
            lines_valid_q <= '0;
            rd_valid_q    <= 1'b0;
            rd_err_q      <= 1'b0;
            rd_data_q     <= '0;
            rd_word_q     <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            wr_lane_q     <= wr_lane_d;
            head_lane_q   <= head_lane_d;
            lines_valid_q <= lines_valid_d;
            rd_valid_q    <= rd_valid_d;
            rd_err_q      <= rd_err_d;
            rd_data_q     <= rd_data_d;
            rd_word_q     <= rd_word_d;
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_err      = rd_err_q;
    assign rd_data     = rd_data_q;
    assign rd_word     = rd_word_q;
    assign lines_valid = lines_valid_q;
    assign head_lane   = head_lane_q;
    assign wr_lane     = wr_lane_q;

endmodule

// File: tb/tb_line_buffer_bank.sv
// Bench for line_buffer_bank: per-cycle compare against a ring model
// plus directed literal checks of fill, wrap, masks, collision and bad address.
module tb_line_buffer_bank;

    localparam int NL = 13;
    localparam int DP = 19;
    localparam int DW = 16;
    localparam int TW = 4;
    localparam int AW = 5;
    localparam int WW = TW + DW;

    logic               clk;
    logic               rst_n;
    logic               wr_valid;
    logic [DW-1:0]      wr_data;
    logic               wr_ready;
    logic               line_release;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic [NL-1:0]      rd_lane_en;
    logic [NL*TW-1:0]   rd_tag;
    logic               rd_valid;
    logic [NL*DW-1:0]   rd_data;
    logic [NL*WW-1:0]   rd_word;
    logic [3:0]         lines_valid;
    logic [3:0]         head_lane;
    logic [3:0]         wr_lane;
    logic               rd_err;

    int checks = 0;
    int errors = 0;

    line_buffer_bank dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .line_release(line_release),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_lane_en(rd_lane_en), .rd_tag(rd_tag),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_word(rd_word),
        .lines_valid(lines_valid), .head_lane(head_lane),
        .wr_lane(wr_lane), .rd_err(rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: plain ring arithmetic over an array of lines.
    int          m_mem [NL][DP];
    int          m_ptr, m_lane, m_head, m_lines;
    bit          m_init = 0;
    logic        e_valid, e_err;
    logic [NL*DW-1:0] e_data;
    logic [NL*WW-1:0] e_word;

    always @(posedge clk) begin
        bit fire, rel;
        int p, d;
        if (!rst_n) begin
            m_ptr = 0; m_lane = 0; m_head = 0; m_lines = 0;
            e_valid = 0; e_err = 0; e_data = '0; e_word = '0;
            m_init = 1;
        end else begin
            fire = wr_valid && (m_lines < NL);
            rel  = line_release && (m_lines > 0);
            e_valid = rd_en;
            if (rd_en) begin
                for (int k = 0; k < NL; k++) begin
`ifdef LINEBUF_ROTATE_EN
                    p = (m_head + k) % NL;
`else
                    p = k;
`endif
                    d = (rd_addr < DP && rd_lane_en[k]) ? m_mem[p][rd_addr] : 0;
                    e_data[k*DW +: DW] = DW'(d);
                    e_word[k*WW +: WW] = {rd_tag[k*TW +: TW], DW'(d)};
                end
                if (rd_addr >= DP) e_err = 1;
            end
            if (fire) begin
                m_mem[m_lane][m_ptr] = int'(wr_data);
                m_ptr++;
                if (m_ptr == DP) begin
                    m_ptr = 0;
                    m_lane = (m_lane + 1) % NL;
                    m_lines++;
                end
            end
            if (rel) begin
                m_lines--;
                m_head = (m_head + 1) % NL;
            end
        end
        #1;
        if (m_init) begin
            chk("rd_valid", rd_valid, e_valid);
            chk("rd_err", rd_err, e_err);
            chk("rd_data", rd_data, e_data);
            chk("rd_word", rd_word, e_word);
            chk("lines_valid", lines_valid, m_lines);
            chk("head_lane", head_lane, m_head);
            chk("wr_lane", wr_lane, m_lane);
            chk("wr_ready", wr_ready, m_lines < NL);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    int lc;

    initial begin
        rst_n = 0; wr_valid = 0; wr_data = '0; line_release = 0;
        rd_en = 0; rd_addr = '0; rd_lane_en = '1; rd_tag = '0;
        cyc(); cyc();
        chk("reset rd_valid", rd_valid, 1'b0);
        chk("reset rd_data", rd_data, '0);
        chk("reset lines", lines_valid, 4'd0);
        chk("reset wr_ready", wr_ready, 1'b1);
        chk("reset rd_err", rd_err, 1'b0);

        rst_n = 1;
        wr_valid = 1;
        for (int i = 0; i < 5; i++) begin
            wr_data = DW'(i + 1);
            cyc();
        end
        wr_valid = 0;
        rst_n = 0;
        cyc();
        rst_n = 1;
        chk("midline reset wr_lane", wr_lane, 4'd0);
        chk("midline reset lines", lines_valid, 4'd0);

        wr_valid = 1;
        for (int l = 0; l < NL; l++) begin
            for (int a = 0; a < DP; a++) begin
                wr_data = DW'(l * 100 + a);
                cyc();
            end
        end
        wr_data = 16'hBEEF;
        cyc();
        wr_valid = 0;
        chk("full lines", lines_valid, 4'd13);
        chk("full wr_ready", wr_ready, 1'b0);
        chk("full wr_lane", wr_lane, 4'd0);

        rd_en = 1; rd_addr = 7;
        cyc();
        chk("fill lane3", rd_data[3*DW +: DW], 16'd307);
        chk("fill lane12", rd_data[12*DW +: DW], 16'd1207);
        rd_addr = 0;
        cyc();
        rd_en = 0;
        chk("extra beat dropped", rd_data[0 +: DW], 16'd0);

        rd_lane_en = 13'h0005;
        rd_tag = '0;
        rd_tag[3:0] = 4'hA;
        rd_tag[11:8] = 4'h3;
        rd_addr = 0; rd_en = 1;
        cyc();
        rd_en = 0;
        chk("mask lane0 word", rd_word[0 +: WW], {4'hA, 16'h0000});
        chk("mask lane1 data", rd_data[DW +: DW], 16'd0);
        chk("mask lane2 word", rd_word[2*WW +: WW], {4'h3, 16'd200});
        rd_lane_en = '1;
        rd_tag = '0;

        line_release = 1;
        cyc();
        line_release = 0;
        chk("release head", head_lane, 4'd1);
        chk("release lines", lines_valid, 4'd12);
        wr_valid = 1;
        for (int a = 0; a < DP; a++) begin
            wr_data = DW'(9000 + a);
            cyc();
        end
        wr_valid = 0;
        rd_en = 1; rd_addr = 4;
        cyc();
        rd_en = 0;
`ifdef LINEBUF_ROTATE_EN
        chk("wrap out12", rd_data[12*DW +: DW], 16'd9004);
        chk("wrap out0", rd_data[0 +: DW], 16'd104);
        lc = 12;
`else
        chk("wrap lane0", rd_data[0 +: DW], 16'd9004);
        lc = 1;
`endif

        line_release = 1;
        cyc();
        line_release = 0;
        wr_valid = 1;
        wr_data = 16'd77;
        cyc();
        wr_data = 16'd78;
        cyc();
        wr_data = 16'd55;
        rd_en = 1; rd_addr = 2;
        cyc();
        wr_valid = 0;
        chk("collision old", rd_data[lc*DW +: DW], 16'd102);
        cyc();
        rd_en = 0;
        chk("collision new", rd_data[lc*DW +: DW], 16'd55);

        wr_valid = 1;
        for (int a = 3; a < DP - 1; a++) begin
            wr_data = DW'(a);
            cyc();
        end
        wr_data = DW'(DP - 1);
        line_release = 1;
        cyc();
        wr_valid = 0;
        line_release = 0;
        chk("done+release lines", lines_valid, 4'd12);
        chk("done+release head", head_lane, 4'd3);
        chk("done+release wr_lane", wr_lane, 4'd2);

        rd_en = 1; rd_addr = 19;
        cyc();
        rd_en = 0;
        chk("bad rd_valid", rd_valid, 1'b1);
        chk("bad rd_data", rd_data, '0);
        chk("bad rd_err", rd_err, 1'b1);
        cyc(); cyc(); cyc();
        chk("err sticky", rd_err, 1'b1);
        chk("idle rd_valid", rd_valid, 1'b0);
        rd_en = 1; rd_addr = 0;
        cyc();
        rd_en = 0;
        chk("err after good read", rd_err, 1'b1);
        rst_n = 0;
        cyc();
        rst_n = 1;
        chk("err cleared", rd_err, 1'b0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
